// File: rtl/sec_tick_timekeeper_pkg.sv
// Shared timekeeping constants, field widths and FSM encoding.
package sec_tick_timekeeper_pkg;
  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {IDLE_RUN, APPLY, REJECT} state_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
  } hms_t;
endpackage

// File: rtl/sec_tick_timekeeper_sync_rise_detect.sv
// Multi-flop synchroniser followed by an edge register; one-cycle rise strobe.
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/sec_tick_timekeeper.sv
// Wall-clock hh:mm:ss driven by a 1 Hz square wave, with glitch guard and set handshake.
module sec_tick_timekeeper
  import sec_tick_timekeeper_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOUR_WRAP   = 24,
  parameter int EDGE_GUARD  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sec_clk_in,
  input  logic              hold,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  output logic              set_err,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic              sec_pulse,
  output logic              day_pulse,
  output logic [7:0]        dropped_cnt
);
  localparam int GW = $clog2(EDGE_GUARD + 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_WRAP - 1);
  localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX);

  state_t         state, state_nxt;
  logic           run_q;
  logic           rise, edge_ok, edge_glitch;
  logic [GW-1:0]  guard_q;
  logic           handshake, in_range, advance, hold_drop, wrap;
  hms_t           latched_q, tnow, tinc;

  sync_rise_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sec_clk_in),
    .rise (rise)
  );

  assign edge_ok     = rise & (guard_q == '0);
  assign edge_glitch = rise & (guard_q != '0);
  assign handshake   = set_valid & set_ready;
  assign in_range    = (set_hour <= HOUR_LAST) && (set_min <= MIN_LAST) && (set_sec <= SEC_LAST);
  // A set in progress (or just accepted) swallows the edge without counting it as dropped.
  assign advance     = (state == IDLE_RUN) & edge_ok & ~hold & ~handshake;
  assign hold_drop   = (state == IDLE_RUN) & edge_ok & hold & ~handshake;
  assign tnow        = '{hour: hour, minute: minute, second: second};
  assign wrap        = (second == SEC_LAST) && (minute == MIN_LAST) && (hour == HOUR_LAST);

  always_comb begin
    tinc = tnow;
    if (second == SEC_LAST) begin
      tinc.second = '0;
      if (minute == MIN_LAST) begin
        tinc.minute = '0;
        tinc.hour   = (hour == HOUR_LAST) ? '0 : hour + 1'b1;
      end else begin
        tinc.minute = minute + 1'b1;
      end
    end else begin
      tinc.second = second + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE_RUN;
    if (state == IDLE_RUN && handshake) state_nxt = in_range ? APPLY : REJECT;
  end

  always_comb begin
    set_ready = run_q && (state == IDLE_RUN);
    set_err   = (state == REJECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      guard_q     <= '0;
      latched_q   <= '0;
      hour        <= '0;
      minute      <= '0;
      second      <= '0;
      sec_pulse   <= 1'b0;
      day_pulse   <= 1'b0;
      dropped_cnt <= '0;
    end else begin
      run_q     <= 1'b1;
      sec_pulse <= advance;
      day_pulse <= advance & wrap;
      if (edge_ok)              guard_q <= GW'(EDGE_GUARD);
      else if (guard_q != '0)   guard_q <= guard_q - 1'b1;
      if (handshake && in_range) latched_q <= '{hour: set_hour, minute: set_min, second: set_sec};
      if (state == APPLY) begin
        hour   <= latched_q.hour;
        minute <= latched_q.minute;
        second <= latched_q.second;
      end else if (advance) begin
        hour   <= tinc.hour;
        minute <= tinc.minute;
        second <= tinc.second;
      end
      if ((edge_glitch || hold_drop) && dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sec_tick_timekeeper.sv
// Directed bench: set-request table plus hand sequences for edge/guard/hold/reset corners.
module tb_sec_tick_timekeeper;
  logic       clk = 1'b0;
  logic       rst_n, sec_clk_in, hold, set_valid;
  logic       set_ready, set_err, sec_pulse, day_pulse;
  logic [4:0] set_hour, hour;
  logic [5:0] set_min, set_sec, minute, second;
  logic [7:0] dropped_cnt;
  int checks = 0, errors = 0;
  int lat, dp;

  always #5 clk = ~clk;

  sec_tick_timekeeper dut (
    .clk(clk), .rst_n(rst_n), .sec_clk_in(sec_clk_in), .hold(hold),
    .set_valid(set_valid), .set_ready(set_ready), .set_hour(set_hour),
    .set_min(set_min), .set_sec(set_sec), .set_err(set_err),
    .hour(hour), .minute(minute), .second(second),
    .sec_pulse(sec_pulse), .day_pulse(day_pulse), .dropped_cnt(dropped_cnt)
  );

  typedef struct {
    logic [4:0] h; logic [5:0] m; logic [5:0] s;
    logic       err;
    logic [4:0] eh; logic [5:0] em; logic [5:0] es;
  } set_vec_t;
  set_vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".hour"}, hour, h);
    chk({name, ".min"},  minute, m);
    chk({name, ".sec"},  second, s);
  endtask

  // One rise of sec_clk_in; lat = cycles until sec_pulse (0 if none), dpo = day_pulse alongside.
  task automatic rise(input int gap, output int lat_o, output int dpo);
    @(negedge clk); sec_clk_in = 1'b1; lat_o = 0; dpo = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (sec_pulse && lat_o == 0) begin lat_o = k; dpo = day_pulse; end
    end
    repeat (12) @(posedge clk);
    @(negedge clk); sec_clk_in = 1'b0;
    repeat (gap - 21) @(posedge clk);
  endtask

  task automatic do_set(input string name, input int h, input int m, input int s,
                        input logic err, input int eh, input int em, input int es);
    @(negedge clk);
    set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s); set_valid = 1'b1;
    @(posedge clk); #1;
    chk({name, ".ready_low"}, set_ready, 0);
    chk({name, ".err"}, set_err, err);
    @(negedge clk); set_valid = 1'b0;
    @(posedge clk); #1;
    chk({name, ".ready_back"}, set_ready, 1);
    chk({name, ".err_clear"}, set_err, 0);
    chk_time(name, eh, em, es);
  endtask

  initial begin
    tbl[0] = '{5'd23, 6'd59, 6'd58, 1'b0, 5'd23, 6'd59, 6'd58};
    tbl[1] = '{5'd24, 6'd0,  6'd0,  1'b1, 5'd23, 6'd59, 6'd58};
    tbl[2] = '{5'd5,  6'd60, 6'd0,  1'b1, 5'd23, 6'd59, 6'd58};
    tbl[3] = '{5'd5,  6'd0,  6'd60, 1'b1, 5'd23, 6'd59, 6'd58};
    tbl[4] = '{5'd0,  6'd0,  6'd0,  1'b0, 5'd0,  6'd0,  6'd0};
    tbl[5] = '{5'd31, 6'd63, 6'd63, 1'b1, 5'd0,  6'd0,  6'd0};
    tbl[6] = '{5'd11, 6'd30, 6'd45, 1'b0, 5'd11, 6'd30, 6'd45};
    tbl[7] = '{5'd23, 6'd59, 6'd58, 1'b0, 5'd23, 6'd59, 6'd58};

    rst_n = 1'b0; sec_clk_in = 1'b0; hold = 1'b0; set_valid = 1'b0;
    set_hour = '0; set_min = '0; set_sec = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst.ready", set_ready, 0);
    chk("rst.err", set_err, 0);
    chk_time("rst", 0, 0, 0);
    chk("rst.dropped", dropped_cnt, 0);
    chk("rst.pulses", {sec_pulse, day_pulse}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.ready", set_ready, 1);

    for (int i = 1; i <= 3; i++) begin
      rise(1100, lat, dp);
      chk($sformatf("clean%0d.latency", i), lat, 3);
      chk($sformatf("clean%0d.sec", i), second, i);
    end

    rise(200, lat, dp);
    chk("glitch.first_lat", lat, 3);
    rise(1100, lat, dp);
    chk("glitch.second_lat", lat, 0);
    chk("glitch.sec", second, 4);
    chk("glitch.dropped", dropped_cnt, 1);

    foreach (tbl[i])
      do_set($sformatf("set%0d", i), tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].err,
             tbl[i].eh, tbl[i].em, tbl[i].es);

    rise(1100, lat, dp);
    chk("wrap1.lat", lat, 3);
    chk("wrap1.day", dp, 0);
    chk_time("wrap1", 23, 59, 59);
    rise(1100, lat, dp);
    chk("wrap2.lat", lat, 3);
    chk("wrap2.day", dp, 1);
    chk_time("wrap2", 0, 0, 0);

    do_set("carry_set", 10, 59, 59, 1'b0, 10, 59, 59);
    rise(1100, lat, dp);
    chk_time("carry", 11, 0, 0);

    // Set request lands on the same cycle as the edge strobe.
    @(negedge clk); sec_clk_in = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); set_hour = 5'd10; set_min = 6'd0; set_sec = 6'd0; set_valid = 1'b1;
    @(posedge clk); #1;
    chk("collide.no_pulse", sec_pulse, 0);
    chk("collide.ready_low", set_ready, 0);
    @(negedge clk); set_valid = 1'b0;
    @(posedge clk); #1;
    chk("collide.no_pulse2", sec_pulse, 0);
    chk_time("collide", 10, 0, 0);
    chk("collide.dropped", dropped_cnt, 1);
    repeat (15) @(posedge clk);
    @(negedge clk); sec_clk_in = 1'b0;
    repeat (10) @(posedge clk);
    rise(1100, lat, dp);
    chk("collide.guard_reload", lat, 0);
    chk("collide.guard_dropped", dropped_cnt, 2);
    chk_time("collide.after", 10, 0, 0);

    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rst2.dropped", dropped_cnt, 0);
    chk_time("rst2", 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rise(1100, lat, dp);
      chk($sformatf("hold%0d.no_pulse", i), lat, 0);
    end
    chk_time("hold", 0, 0, 0);
    chk("hold.dropped", dropped_cnt, 4);

    @(negedge clk); set_hour = 5'd12; set_min = 6'd34; set_sec = 6'd56; set_valid = 1'b1;
    @(posedge clk); #1;
    chk("apply.ready_low", set_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("apply_rst.ready", set_ready, 0);
    chk("apply_rst.dropped", dropped_cnt, 0);
    chk_time("apply_rst", 0, 0, 0);
    set_valid = 1'b0; hold = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk_time("apply_rst.after", 0, 0, 0);
    chk("apply_rst.ready_back", set_ready, 1);
    chk("apply_rst.err", set_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
